idli_sqi_mem_m: RTL and testbench



---
 rtl/idli_sqi_mem_m.sv | 186 ++++++++++++++++++
 tb/tb_idli_sqi_mem_m.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_mem_m.sv
// SQI serial-SRAM responder: decodes command/address/dummy nibbles and serves
// sequential byte reads and writes against an internal array.
module idli_sqi_mem_m #(
  parameter int         ADDR_W = 8,
  parameter logic [7:0] RD_CMD = 8'h03,
  parameter logic [7:0] WR_CMD = 8'h02
) (
  input  logic       i_mem_gck,
  input  logic       i_mem_rst_n,
  input  logic       i_mem_sqi_sck,
  input  logic       i_mem_sqi_cs,
  input  logic [3:0] i_mem_sqi_data,
  output logic [3:0] o_mem_sqi_data,
  output logic       o_mem_sqi_oe,
  output logic       o_mem_busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_RD     = 3'd4;
  localparam logic [2:0] ST_WR     = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        sck_q, sck_d;
  logic [15:0] addr_q, addr_d;
  logic [3:0]  cmd_hi_q, cmd_hi_d;
  logic        is_wr_q, is_wr_d;
  logic [3:0]  hold_q, hold_d;
  logic        half_q, half_d;
  logic        wr_pend_q, wr_pend_d;
  logic [7:0]  wr_byte_q, wr_byte_d;
  logic [3:0]  data_q, data_d;
  logic        oe_q, oe_d;

  logic [7:0]  mem_q [0:(1<<ADDR_W)-1];
  logic [15:0] addr_inc;
  logic [7:0]  rd_cur, rd_next;
  logic        rise, fall;

  assign addr_inc = addr_q + 16'd1;
  assign rd_cur   = mem_q[addr_q[ADDR_W-1:0]];
  assign rd_next  = mem_q[addr_inc[ADDR_W-1:0]];
  assign rise     = i_mem_sqi_sck & ~sck_q & ~i_mem_sqi_cs;
  assign fall     = ~i_mem_sqi_sck & sck_q & ~i_mem_sqi_cs;

  // NOTE: every _d gets its current value first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sck_d     = i_mem_sqi_sck;
    addr_d    = addr_q;
    cmd_hi_d  = cmd_hi_q;
    is_wr_d   = is_wr_q;
    hold_d    = hold_q;
    half_d    = half_q;
    wr_pend_d = 1'b0;
    wr_byte_d = wr_byte_q;
    data_d    = data_q;
    oe_d      = oe_q;

    // A completed byte commits one clock after its second nibble, even if cs rises.
    if (wr_pend_q) addr_d = addr_inc;

    if (i_mem_sqi_cs) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      half_d  = 1'b0;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          cnt_d   = 2'd0;
          half_d  = 1'b0;
          if (rise) begin
            cmd_hi_d = i_mem_sqi_data;
            cnt_d    = 2'd1;
          end
        end
        ST_CMD: if (rise) begin
          if (cnt_q == 2'd0) begin
            cmd_hi_d = i_mem_sqi_data;
            cnt_d    = 2'd1;
          end else begin
            cnt_d = 2'd0;
            if ({cmd_hi_q, i_mem_sqi_data} == RD_CMD) begin
              state_d = ST_ADDR;
              is_wr_d = 1'b0;
            end else if ({cmd_hi_q, i_mem_sqi_data} == WR_CMD) begin
              state_d = ST_ADDR;
              is_wr_d = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR: if (rise) begin
          addr_d = {addr_q[11:0], i_mem_sqi_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = is_wr_q ? ST_WR : ST_DUMMY;
        end
        ST_DUMMY: if (rise) begin
          cnt_d = 2'd1;
          if (cnt_q == 2'd1) begin
            state_d = ST_RD;
            cnt_d   = 2'd0;
          end
        end
        ST_RD: if (fall) begin
          // cnt_q==0 marks the very first nibble, which must not advance the address.
          oe_d = 1'b1;
          if (!half_q) begin
            half_d = 1'b1;
            cnt_d  = 2'd1;
            if (cnt_q != 2'd0) begin
              addr_d = addr_inc;
              data_d = rd_next[7:4];
            end else begin
              data_d = rd_cur[7:4];
            end
          end else begin
            half_d = 1'b0;
            data_d = rd_cur[3:0];
          end
        end
        ST_WR: if (rise) begin
          if (!half_q) begin
            hold_d = i_mem_sqi_data;
            half_d = 1'b1;
          end else begin
            wr_byte_d = {hold_q, i_mem_sqi_data};
            wr_pend_d = 1'b1;
            half_d    = 1'b0;
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_mem_gck) begin
    if (!i_mem_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      sck_q     <= 1'b0;
      addr_q    <= 16'd0;
      cmd_hi_q  <= 4'd0;
      is_wr_q   <= 1'b0;
      hold_q    <= 4'd0;
      half_q    <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_byte_q <= 8'd0;
      data_q    <= 4'd0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sck_q     <= sck_d;
      addr_q    <= addr_d;
      cmd_hi_q  <= cmd_hi_d;
      is_wr_q   <= is_wr_d;
      hold_q    <= hold_d;
      half_q    <= half_d;
      wr_pend_q <= wr_pend_d;
      wr_byte_q <= wr_byte_d;
      data_q    <= data_d;
      oe_q      <= oe_d;
    end
  end

  // NOTE: the array has no reset; only the commit is gated so a pending byte is dropped by reset.
  always_ff @(posedge i_mem_gck) begin
    if (i_mem_rst_n && wr_pend_q) mem_q[addr_q[ADDR_W-1:0]] <= wr_byte_q;
  end

  assign o_mem_sqi_data = data_q;
  assign o_mem_sqi_oe   = oe_q;
  assign o_mem_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Self-checking bench for idli_sqi_mem_m: directed scenarios plus random
// write/read traffic compared against a byte-array reference model.
module tb_idli_sqi_mem_m;

  localparam logic [7:0] RD = 8'h03;
  localparam logic [7:0] WR = 8'h02;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       cs = 1'b1;
  logic [3:0] din = 4'd0;
  logic [3:0] dout;
  logic       oe, busy;

  int total = 0;
  int bad = 0;
  logic [7:0] ref_mem [256];

  idli_sqi_mem_m dut (
    .i_mem_gck      (clk),
    .i_mem_rst_n    (rst_n),
    .i_mem_sqi_sck  (sck),
    .i_mem_sqi_cs   (cs),
    .i_mem_sqi_data (din),
    .o_mem_sqi_data (dout),
    .o_mem_sqi_oe   (oe),
    .o_mem_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCK period: high for 2 gck, low for 2 gck; ends just before the next rise.
  task automatic pulse(input logic [3:0] nib);
    din = nib;
    sck = 1'b1;
    cyc(2);
    sck = 1'b0;
    cyc(2);
  endtask

  task automatic end_tx(input string name);
    cs  = 1'b1;
    din = 4'd0;
    cyc(2);
    total++;
    if (oe !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle: oe=%b busy=%b want oe=0 busy=0", name, oe, busy);
    end
  endtask

  task automatic start_tx(input logic [7:0] cmd, input logic [15:0] a, input string name);
    cs = 1'b0;
    pulse(cmd[7:4]);
    pulse(cmd[3:0]);
    for (int i = 3; i >= 0; i--) pulse(a[i*4 +: 4]);
    total++;
    if (oe !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s header: oe=%b busy=%b want oe=0 busy=1", name, oe, busy);
    end
  endtask

  task automatic write_bytes(input string name, input logic [15:0] a,
                             input logic [7:0] q[$], input logic partial,
                             input logic [3:0] pnib);
    start_tx(WR, a, name);
    foreach (q[i]) begin
      pulse(q[i][7:4]);
      pulse(q[i][3:0]);
      ref_mem[(int'(a) + i) % 256] = q[i];
    end
    if (partial) pulse(pnib);
    end_tx(name);
  endtask

  // Two dummy periods; the fall of the second presents nibble 0.
  task automatic read_check(input string name, input logic [15:0] a, input int n);
    logic [7:0] b;
    logic [3:0] exp;
    start_tx(RD, a, name);
    pulse(4'($urandom));
    for (int i = 0; i < n; i++) begin
      pulse(4'($urandom));
      b   = ref_mem[(int'(a) + i / 2) % 256];
      exp = (i % 2 == 0) ? b[7:4] : b[3:0];
      total++;
      if (dout !== exp || oe !== 1'b1) begin
        bad++;
        $display("FAIL %s nib%0d: data=%h oe=%b want data=%h oe=1", name, i, dout, oe, exp);
      end
    end
    end_tx(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cs    = 1'b1;
    cyc(3);
    total++;
    if (busy !== 1'b0 || oe !== 1'b0 || dout !== 4'd0) begin
      bad++;
      $display("FAIL reset: busy=%b oe=%b data=%h want 0 0 0", busy, oe, dout);
    end
    rst_n = 1'b1;
    cyc(2);
    total++;
    if (busy !== 1'b0 || oe !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: busy=%b oe=%b want 0 0", busy, oe);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] q[$];
    q = '{8'hA5};
    write_bytes("wr_rd", 16'h0010, q, 1'b0, 4'd0);
    total++;
    if (ref_mem[8'h10] !== 8'hA5) begin
      bad++;
      $display("FAIL wr_rd model: got %h want a5", ref_mem[8'h10]);
    end
    read_check("wr_rd", 16'h0010, 2);
  endtask

  task automatic test_burst();
    logic [7:0] q[$];
    q = '{8'h11, 8'h22, 8'h33};
    write_bytes("burst", 16'h0020, q, 1'b0, 4'd0);
    read_check("burst", 16'h0020, 6);
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    q = '{8'hDE};
    write_bytes("wrap_ff", 16'h00FF, q, 1'b0, 4'd0);
    q = '{8'hAD};
    write_bytes("wrap_00", 16'h0000, q, 1'b0, 4'd0);
    read_check("wrap", 16'h00FF, 4);
    read_check("wrap_alias", 16'h01FF, 4);
  endtask

  task automatic test_ignore();
    cs = 1'b0;
    pulse(4'hF);
    pulse(4'hF);
    for (int i = 0; i < 8; i++) begin
      pulse(4'($urandom));
      total++;
      if (oe !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL ignore p%0d: oe=%b busy=%b want oe=0 busy=1", i, oe, busy);
      end
    end
    cs = 1'b1;
    cyc(1);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_idle: busy=%b want 0", busy);
    end
    cyc(1);
    read_check("ignore_mem", 16'h0010, 2);
    read_check("ignore_mem2", 16'h0020, 6);
  endtask

  task automatic test_partial();
    logic [7:0] q[$];
    q = '{8'h77};
    write_bytes("partial_init", 16'h0040, q, 1'b0, 4'd0);
    q = {};
    write_bytes("partial", 16'h0040, q, 1'b1, 4'h9);
    read_check("partial", 16'h0040, 2);
  endtask

  task automatic test_reset_mid_read();
    start_tx(RD, 16'h0010, "rst_mid");
    pulse(4'd0);
    pulse(4'd0);
    pulse(4'd0);
    rst_n = 1'b0;
    cyc(1);
    total++;
    if (oe !== 1'b0 || busy !== 1'b0 || dout !== 4'd0) begin
      bad++;
      $display("FAIL rst_mid: oe=%b busy=%b data=%h want 0 0 0", oe, busy, dout);
    end
    cs    = 1'b1;
    rst_n = 1'b1;
    cyc(2);
    read_check("rst_mid_after", 16'h0010, 2);
  endtask

  task automatic test_random();
    logic [7:0]  q[$];
    logic [15:0] a;
    int          n;
    q = {};
    for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
    write_bytes("rnd_fill", 16'($urandom), q, 1'b0, 4'd0);
    for (int k = 0; k < 25; k++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(1, 5);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        write_bytes("rnd_wr", a, q, 1'($urandom), 4'($urandom));
      end else begin
        read_check("rnd_rd", a, $urandom_range(1, 12));
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read();
    test_burst();
    test_wrap();
    test_ignore();
    test_partial();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
